t_using_d_counter: RTL

T_USING_D_COUNTER -- requirements
Module: t_using_d_counter

---
 rtl/ff_conv_pkg.sv | 9 +
 rtl/tff_from_dff.sv | 18 +
 rtl/t_using_d_counter.sv | 69 ++++++
 3 files changed

// File: rtl/ff_conv_pkg.sv
// Shared constants for the flip-flop conversion counters: default width
// and the direction encoding used on the up input.
package ff_conv_pkg;

    localparam int   WIDTH_DEFAULT = 4;
    localparam logic DIR_UP        = 1'b1;
    localparam logic DIR_DOWN      = 1'b0;

endpackage

// File: rtl/tff_from_dff.sv
// T flip-flop built from a D flip-flop: D = t ^ q, synchronous active-high
// reset clears the stored bit.
module tff_from_dff (
    input  logic t,
    input  logic clk,
    input  logic reset,
    output logic q
);

    always_ff @(posedge clk) begin
        if (reset) begin
            q <= 1'b0;
        end else begin
            q <= t ^ q;
        end
    end

endmodule

// File: rtl/t_using_d_counter.sv
// Up/down counter with parallel load whose state lives entirely in T flip-flops.
// Define T_USING_D_COUNTER_SAT_EN to saturate at the terminal count instead of wrapping.
module t_using_d_counter
    import ff_conv_pkg::*;
#(
    parameter int WIDTH = WIDTH_DEFAULT
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic             up,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic [WIDTH-1:0] q,
    output logic             tc,
    output logic             wrap
);

    logic [WIDTH-1:0] t;
    logic             wrap_next;

    assign tc = (up == DIR_UP) ? (&q) : ~(|q);

    // Each T bit toggles when every lower bit is at its terminal value for the
    // current direction; a running carry gives the prefix AND without slicing.
    always_comb begin
        logic carry;
        t         = '0;
        wrap_next = 1'b0;
        carry     = 1'b1;
        if (load) begin
            t = load_val ^ q;
        end else if (en) begin
`ifdef T_USING_D_COUNTER_SAT_EN
            if (!tc) begin
                for (int i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & ((up == DIR_UP) ? q[i] : ~q[i]);
                end
            end
`else
            for (int i = 0; i < WIDTH; i++) begin
                t[i]  = carry;
                carry = carry & ((up == DIR_UP) ? q[i] : ~q[i]);
            end
            // Stepping while at the terminal count is exactly a boundary crossing.
            wrap_next = tc;
`endif
        end
    end

    for (genvar i = 0; i < WIDTH; i++) begin : g_bit
        tff_from_dff u_tff (
            .t     (t[i]),
            .clk   (clk),
            .reset (reset),
            .q     (q[i])
        );
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            wrap <= 1'b0;
        end else begin
            wrap <= wrap_next;
        end
    end

endmodule
